// File: rtl/fe_atr_sequencer.sv
// fe_atr_sequencer: per-radio front-end ATR code sequencer with TX guard intervals.
// FE_ATR_GUARD_EN builds the guard FSM; without it gpio_out simply follows code[{run_tx,run_rx}].
module fe_atr_sequencer #(
    parameter logic [7:0]  SR_BASE          = 8'd0,
    parameter logic [15:0] TX_ON_DELAY_RST  = 16'd40,
    parameter logic [15:0] TX_OFF_DELAY_RST = 16'd40
) (
    input  logic        radio_clk,
    input  logic        radio_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        run_rx,
    input  logic        run_tx,
    output logic [7:0]  gpio_out,
    output logic        busy
);
    logic [7:0] code [4];
    logic [1:0] t;
    assign t = {run_tx, run_rx};
    always_ff @(posedge radio_clk) begin
        for (int i = 0; i < 4; i++)
            if (radio_rst)
                code[i] <= 8'h00;
            else if (set_stb && set_addr == SR_BASE + 8'(i))
                code[i] <= set_data[7:0];
    end
`ifdef FE_ATR_GUARD_EN
    localparam logic [1:0] STABLE = 2'd0, ON_WAIT = 2'd1, OFF_WAIT = 2'd2;
    logic [1:0]  state, state_n, cur, cur_n;
    logic [15:0] cnt, cnt_n, on_dly, off_dly;
    logic        dly_wr;
    assign dly_wr = set_stb && set_addr == SR_BASE + 8'd4;
    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        case (state)
            STABLE:
                if (cur[1] && !t[1]) begin
                    state_n = OFF_WAIT;
                    cnt_n   = off_dly;
                end else if (t[1] && !cur[1]) begin
                    cur_n   = t;
                    state_n = ON_WAIT;
                    cnt_n   = on_dly;
                end else
                    cur_n = t;
            ON_WAIT: begin
                // losing TX here needs no off guard: tx_enable never went high
                cur_n = t;
                if (!t[1] || cnt == 16'd0) state_n = STABLE;
                else cnt_n = cnt - 16'd1;
            end
            OFF_WAIT:
                if (cnt == 16'd0) begin
                    cur_n   = {1'b0, t[0]};
                    state_n = STABLE;
                end else
                    cnt_n = cnt - 16'd1;
            default: state_n = STABLE;
        endcase
    end
    // tx_enable is only passed through once the next state is settled
    always_ff @(posedge radio_clk) begin
        if (radio_rst) begin
            state    <= STABLE;
            cur      <= 2'b00;
            cnt      <= 16'd0;
            on_dly   <= TX_ON_DELAY_RST;
            off_dly  <= TX_OFF_DELAY_RST;
            gpio_out <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            cnt      <= cnt_n;
            on_dly   <= dly_wr ? set_data[15:0] : on_dly;
            off_dly  <= dly_wr ? set_data[31:16] : off_dly;
            gpio_out <= state_n == STABLE ? code[cur_n] : {1'b0, code[cur_n][6:0]};
            busy     <= state_n != STABLE;
        end
    end
`else
    logic unused_dly;
    assign unused_dly = ^set_data[31:8];
    assign busy = 1'b0;
    always_ff @(posedge radio_clk) begin
        if (radio_rst) gpio_out <= 8'h00;
        else gpio_out <= code[t];
    end
`endif
endmodule

// File: tb/tb_fe_atr_sequencer.sv
// tb_fe_atr_sequencer: directed checks of the ATR sequencer for whichever build
// (FE_ATR_GUARD_EN defined or not) it is compiled with.
module tb_fe_atr_sequencer;
    logic        radio_clk = 1'b0;
    logic        radio_rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic        run_rx = 1'b0;
    logic        run_tx = 1'b0;
    logic [7:0]  gpio_out;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    fe_atr_sequencer dut (
        .radio_clk(radio_clk), .radio_rst(radio_rst), .set_stb(set_stb),
        .set_addr(set_addr), .set_data(set_data), .run_rx(run_rx),
        .run_tx(run_tx), .gpio_out(gpio_out), .busy(busy)
    );

    always #5 radio_clk = ~radio_clk;

    task automatic step();
        @(posedge radio_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        step();
        set_stb = 1'b0;
    endtask

    task automatic setup();
        wr(8'd0, 32'h01);
        wr(8'd1, 32'h12);
        wr(8'd2, 32'hA4);
        wr(8'd3, 32'hC8);
        wr(8'd4, {16'd2, 16'd3});
        step();
        step();
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_gpio", gpio_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        radio_rst = 1'b0;
        setup();
        chk("idle", gpio_out, 8'h01);
        run_rx = 1'b1;
        step();
        chk("rx", gpio_out, 8'h12);
        chk("rx_busy", busy, 1'b0);
`ifdef FE_ATR_GUARD_EN
        run_rx = 1'b0;
        run_tx = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("on_wait_gpio", gpio_out, 8'h24);
            chk("on_wait_busy", busy, 1'b1);
        end
        step();
        chk("tx", gpio_out, 8'hA4);
        chk("tx_busy", busy, 1'b0);
        run_tx = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("off_wait_gpio", gpio_out, 8'h24);
            chk("off_wait_busy", busy, 1'b1);
        end
        step();
        chk("off_done", gpio_out, 8'h01);
        chk("off_done_busy", busy, 1'b0);
        run_tx = 1'b1;
        step();
        chk("abort_switch", gpio_out, 8'h24);
        run_tx = 1'b0;
        step();
        chk("abort_gpio", gpio_out, 8'h01);
        chk("abort_busy", busy, 1'b0);
        step();
        chk("abort_hold", gpio_out, 8'h01);
        run_tx = 1'b1;
        repeat (5) step();
        chk("tx_again", gpio_out, 8'hA4);
        run_rx = 1'b1;
        step();
        chk("fdx", gpio_out, 8'hC8);
        chk("fdx_busy", busy, 1'b0);
        run_rx = 1'b0;
        step();
        chk("fdx_to_tx", gpio_out, 8'hA4);
        run_tx = 1'b0;
        step();
        chk("exit_start", gpio_out, 8'h24);
        radio_rst = 1'b1;
        step();
        chk("midrst_gpio", gpio_out, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        radio_rst = 1'b0;
        run_rx = 1'b1;
        step();
        chk("rst_rx_code", gpio_out, 8'h00);
        run_rx = 1'b0;
        step();
        run_tx = 1'b1;
        step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("on_rst_guard", 16'(n), 16'd41);
        run_tx = 1'b0;
        step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("off_rst_guard", 16'(n), 16'd41);
        wr(8'd2, 32'hA4);
        wr(8'd4, 32'h0);
        step();
        run_tx = 1'b1;
        step();
        chk("on0_gpio", gpio_out, 8'h24);
        chk("on0_busy", busy, 1'b1);
        step();
        chk("on0_tx", gpio_out, 8'hA4);
        run_tx = 1'b0;
        step();
        chk("off0_gpio", gpio_out, 8'h24);
        step();
        chk("off0_idle", gpio_out, 8'h00);
        chk("off0_busy", busy, 1'b0);
`else
        run_rx = 1'b0;
        run_tx = 1'b1;
        step();
        chk("tx", gpio_out, 8'hA4);
        chk("tx_busy", busy, 1'b0);
        step();
        chk("tx_hold", gpio_out, 8'hA4);
        run_rx = 1'b1;
        step();
        chk("fdx", gpio_out, 8'hC8);
        run_tx = 1'b0;
        step();
        chk("fdx_to_rx", gpio_out, 8'h12);
        run_rx = 1'b0;
        step();
        chk("rx_to_idle", gpio_out, 8'h01);
        wr(8'd0, 32'h55);
        step();
        chk("code_write", gpio_out, 8'h55);
        wr(8'd4, 32'h0);
        step();
        chk("dly_write", gpio_out, 8'h55);
        run_tx = 1'b1;
        radio_rst = 1'b1;
        step();
        chk("midrst_gpio", gpio_out, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        radio_rst = 1'b0;
        step();
        chk("rst_tx_code", gpio_out, 8'h00);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
